epc_stack: RTL and testbench
============================

Name: epc_stack

Overview:
- Parametrised successor to the single EPC holding register, for nested exceptions.
- Keeps a LIFO of saved exception PCs, up to Depth deep.
- Exception entry pushes the faulting PC; ERET pops it; MTC0 EPC overwrites the top.
- Sits in the CPU memory/CP0 area. The top entry is the architectural EPC seen by MFC0 and the ERET path.

Parameters:
NrOfBits, 32, width of each stored PC
Depth, 4, number of stack entries (>=1); Depth=1 behaves as a plain EPC register
CountBits, 3, width of Count; must satisfy 2^CountBits > Depth

Ports:
Clock  input  1  system clock; all state changes on rising edge
Reset  input  1  synchronous, active-high; clears all entries, Count and flags
ClockEnable  input  1  global enable; qualifies every operation
Tick  input  1  single-step/clock-divider tick; qualifies every operation
Push  input  1  exception entry: save PushData as new top
PushData  input  NrOfBits  PC to save on Push
Pop  input  1  ERET: discard top, previous entry becomes top
Write  input  1  MTC0 EPC: overwrite top with D
D  input  NrOfBits  write data for Write
ClearFlags  input  1  clears sticky Overflow/Underflow
cs  input  1  output disable, active-high
Q  output  NrOfBits  top entry; forced to 0 while cs=1
Count  output  CountBits  number of valid entries, 0..Depth
Empty  output  1  Count==0
Full  output  1  Count==Depth
Overflow  output  1  sticky: a Push was made while Full
Underflow  output  1  sticky: a Pop was made while Empty

Behaviour:
- Clock and enable:
  - en = ClockEnable & Tick.
  - When en=0, nothing changes except Reset and ClearFlags.
- Reset (Reset=1 at rising edge) has highest priority, and wins over ClearFlags and any operation. Afterwards:
  - all entries = 0, Count=0, Overflow=0, Underflow=0;
  - so Q=0, Empty=1, Full=0.
- Storage:
  - A shift array entry[0..Depth-1]; entry[0] is the top.
  - Vacated slots are refilled with 0, so Q reads 0 whenever Empty.
- Operation priority when en=1, one operation per cycle:
  - Push&Pop (replace) > Push > Pop > Write.
  - Write in the same cycle as Push or Pop is ignored.
- Push only:
  - entry[i+1] <= entry[i] for all i; entry[0] <= PushData.
  - If not Full, Count+1.
  - If Full, the oldest entry (entry[Depth-1]) is dropped, Count stays Depth, Overflow <= 1.
- Pop only:
  - entry[i] <= entry[i+1]; entry[Depth-1] <= 0; Count-1.
  - If Empty: no data/Count change, Underflow <= 1.
- Push&Pop together (exception taken in the ERET cycle):
  - entry[0] <= PushData, other entries unchanged.
  - If Count=0, Count becomes 1; otherwise Count is unchanged.
  - No flag change.
- Write only:
  - entry[0] <= D.
  - If Empty, Count becomes 1; otherwise Count is unchanged.
- ClearFlags:
  - Evaluated at the rising edge, independent of en; takes effect next cycle.
  - If the same edge also sets a flag (overflow Push or underflow Pop), the set wins.
- Outputs:
  - Q, Empty, Full, Count and the flags are driven directly from registers; no combinational path from Push/Pop/Write/D.
  - Effect of an operation is visible one cycle after the edge.
  - cs gates only Q, combinationally; internal state is unaffected by cs.
- Depth=1:
  - Push always overwrites entry[0].
  - A Push when Count=1 sets Overflow.
- Widths: Count arithmetic saturates at 0 and Depth; never wraps.

Test Plan:
- Reset then idle -> Q=0, Count=0, Empty=1, Full=0, Overflow=0, Underflow=0; Push with Tick=0 -> no change.
- Depth=4: Push 0x100, 0x200, 0x300 (en=1) -> Q=0x300, Count=3. Then Pop, Pop -> Q=0x100, Count=1. Then Pop -> Q=0, Empty=1.
- Depth=4: Push 0x10, 0x20, 0x30, 0x40, 0x50 -> Full=1, Count=4, Overflow=1, Q=0x50. Pop x4 -> Q sequence 0x40, 0x30, 0x20, then 0 with Empty=1 (0x10 was dropped).
- Empty, Pop -> Underflow=1, Count=0. ClearFlags plus a second Pop in the same cycle -> Underflow stays 1. ClearFlags alone -> Underflow=0.
- Count=2 (top 0x200): Push&Pop with PushData=0x999 -> Q=0x999, Count=2. Write D=0xABC with Pop in the same cycle -> Write ignored, Count=1.
- Empty: Write D=0x1234 -> Q=0x1234, Count=1. cs=1 -> Q=0, Count still 1. Reset mid-sequence at Count=3 -> all cleared next cycle.

Source files
------------

// File: rtl/epc_stack.sv
// epc_stack: LIFO of saved exception PCs for nested exceptions.
// Exception entry pushes the faulting PC, ERET pops it, and MTC0 EPC
// overwrites the top. entry[0] is the architectural EPC. Vacated slots
// are refilled with zero, so Q reads 0 whenever the stack is empty.
module epc_stack #(
    parameter int NrOfBits  = 32,
    parameter int Depth     = 4,
    parameter int CountBits = 3
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 ClockEnable,
    input  logic                 Tick,
    input  logic                 Push,
    input  logic [NrOfBits-1:0]  PushData,
    input  logic                 Pop,
    input  logic                 Write,
    input  logic [NrOfBits-1:0]  D,
    input  logic                 ClearFlags,
    input  logic                 cs,
    output logic [NrOfBits-1:0]  Q,
    output logic [CountBits-1:0] Count,
    output logic                 Empty,
    output logic                 Full,
    output logic                 Overflow,
    output logic                 Underflow
);

    localparam logic [CountBits-1:0] DepthCount = CountBits'(Depth);
    localparam logic [CountBits-1:0] OneCount   = CountBits'(1);

    typedef enum logic [2:0] {
        OpNone,
        OpReplace,
        OpPush,
        OpPop,
        OpWrite
    } op_t;

    logic [NrOfBits-1:0]  entry      [Depth];
    logic [NrOfBits-1:0]  entry_next [Depth];
    logic [CountBits-1:0] count_reg;
    logic [CountBits-1:0] count_next;
    logic                 overflow_reg;
    logic                 underflow_reg;
    logic                 overflow_set;
    logic                 underflow_set;
    logic                 en;
    logic                 is_empty;
    logic                 is_full;
    op_t                  op;

    assign en       = ClockEnable & Tick;
    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == DepthCount);

    // Pick the single operation performed this cycle, highest priority first.
    always_comb begin
        // NOTE: each variable written here gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        op = OpNone;
        if (en) begin
            if (Push && Pop) begin
                op = OpReplace;
            end else if (Push) begin
                op = OpPush;
            end else if (Pop) begin
                op = OpPop;
            end else if (Write) begin
                op = OpWrite;
            end
        end
    end

    // Compute next entries, next count and flag-set conditions for the chosen operation.
    always_comb begin
        entry_next    = entry;
        count_next    = count_reg;
        overflow_set  = 1'b0;
        underflow_set = 1'b0;
        unique case (op)
            OpReplace: begin
                // Exception taken in the ERET cycle: top is replaced, depth kept.
                entry_next[0] = PushData;
                if (is_empty) begin
                    count_next = OneCount;
                end
            end
            OpPush: begin
                for (int i = Depth - 1; i > 0; i--) begin
                    entry_next[i] = entry[i-1];
                end
                entry_next[0] = PushData;
                if (is_full) begin
                    // Oldest entry falls off the bottom; depth stays saturated.
                    overflow_set = 1'b1;
                end else begin
                    count_next = count_reg + OneCount;
                end
            end
            OpPop: begin
                if (is_empty) begin
                    underflow_set = 1'b1;
                end else begin
                    for (int i = 0; i < Depth - 1; i++) begin
                        entry_next[i] = entry[i+1];
                    end
                    entry_next[Depth-1] = '0;
                    count_next          = count_reg - OneCount;
                end
            end
            OpWrite: begin
                entry_next[0] = D;
                if (is_empty) begin
                    count_next = OneCount;
                end
            end
            default: begin
            end
        endcase
    end

    // Register state; reset dominates, ClearFlags acts regardless of enable, a same-edge set wins.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            // NOTE: the entry array is reset (not left as plain memory) because Q must read 0 after reset.
            for (int i = 0; i < Depth; i++) begin
                entry[i] <= '0;
            end
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            entry         <= entry_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_set | (overflow_reg & ~ClearFlags);
            underflow_reg <= underflow_set | (underflow_reg & ~ClearFlags);
        end
    end

    assign Q         = cs ? '0 : entry[0];
    assign Count     = count_reg;
    assign Empty     = is_empty;
    assign Full      = is_full;
    assign Overflow  = overflow_reg;
    assign Underflow = underflow_reg;

endmodule

// File: tb/tb_epc_stack.sv
// tb_epc_stack: directed stimulus for epc_stack (Depth=4) with a queue-based
// reference model compared on every falling edge, plus literal expectations.
module tb_epc_stack;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CB    = 3;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          ClockEnable;
    logic          Tick;
    logic          Push;
    logic [W-1:0]  PushData;
    logic          Pop;
    logic          Write;
    logic [W-1:0]  D;
    logic          ClearFlags;
    logic          cs;
    logic [W-1:0]  Q;
    logic [CB-1:0] Count;
    logic          Empty;
    logic          Full;
    logic          Overflow;
    logic          Underflow;

    epc_stack #(.NrOfBits(W), .Depth(DEPTH), .CountBits(CB)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ClockEnable(ClockEnable),
        .Tick       (Tick),
        .Push       (Push),
        .PushData   (PushData),
        .Pop        (Pop),
        .Write      (Write),
        .D          (D),
        .ClearFlags (ClearFlags),
        .cs         (cs),
        .Q          (Q),
        .Count      (Count),
        .Empty      (Empty),
        .Full       (Full),
        .Overflow   (Overflow),
        .Underflow  (Underflow)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int passed = 0;
    bit compare_on = 1'b0;

    // Reference model: front of the queue is the top of stack.
    logic [W-1:0] model_q[$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;
    bit           ovf_set;
    bit           unf_set;
    logic [W-1:0] exp_q;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model update at each rising edge from the inputs present at that edge.
    always @(posedge Clock) begin
        if (Reset) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            ovf_set = 1'b0;
            unf_set = 1'b0;
            if (ClockEnable && Tick) begin
                if (Push && Pop) begin
                    if (model_q.size() == 0) model_q.push_front(PushData);
                    else model_q[0] = PushData;
                end else if (Push) begin
                    model_q.push_front(PushData);
                    if (model_q.size() > DEPTH) begin
                        void'(model_q.pop_back());
                        ovf_set = 1'b1;
                    end
                end else if (Pop) begin
                    if (model_q.size() == 0) unf_set = 1'b1;
                    else void'(model_q.pop_front());
                end else if (Write) begin
                    if (model_q.size() == 0) model_q.push_front(D);
                    else model_q[0] = D;
                end
            end
            m_ovf = ovf_set | (m_ovf & !ClearFlags);
            m_unf = unf_set | (m_unf & !ClearFlags);
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge Clock) begin
        if (compare_on) begin
            exp_q = (cs || model_q.size() == 0) ? '0 : model_q[0];
            check("model Q",         Q,                exp_q);
            check("model Count",     32'(Count),       32'(model_q.size()));
            check("model Empty",     32'(Empty),       32'(model_q.size() == 0));
            check("model Full",      32'(Full),        32'(model_q.size() == DEPTH));
            check("model Overflow",  32'(Overflow),    32'(m_ovf));
            check("model Underflow", 32'(Underflow),   32'(m_unf));
        end
    end

    task automatic step(input logic push, input logic pop, input logic write,
                        input logic [31:0] pd, input logic [31:0] d, input logic clr);
        Push       = push;
        Pop        = pop;
        Write      = write;
        PushData   = pd;
        D          = d;
        ClearFlags = clr;
        @(posedge Clock);
        #1;
        Push       = 1'b0;
        Pop        = 1'b0;
        Write      = 1'b0;
        ClearFlags = 1'b0;
    endtask

    initial begin
        Reset       = 1'b1;
        ClockEnable = 1'b1;
        Tick        = 1'b1;
        Push        = 1'b0;
        PushData    = '0;
        Pop         = 1'b0;
        Write       = 1'b0;
        D           = '0;
        ClearFlags  = 1'b0;
        cs          = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset      = 1'b0;
        compare_on = 1'b1;

        // Reset state and idle
        check("reset Q",         Q,               32'h0);
        check("reset Count",     32'(Count),      32'd0);
        check("reset Empty",     32'(Empty),      32'd1);
        check("reset Full",      32'(Full),       32'd0);
        check("reset Overflow",  32'(Overflow),   32'd0);
        check("reset Underflow", 32'(Underflow),  32'd0);

        // Push with Tick low does nothing
        Tick = 1'b0;
        step(1, 0, 0, 32'h55, 0, 0);
        check("tick0 Count", 32'(Count), 32'd0);
        check("tick0 Q",     Q,          32'h0);
        Tick = 1'b1;

        // Basic push/pop
        step(1, 0, 0, 32'h100, 0, 0);
        step(1, 0, 0, 32'h200, 0, 0);
        step(1, 0, 0, 32'h300, 0, 0);
        check("push3 Q",     Q,          32'h300);
        check("push3 Count", 32'(Count), 32'd3);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check("pop2 Q",     Q,          32'h100);
        check("pop2 Count", 32'(Count), 32'd1);
        step(0, 1, 0, 0, 0, 0);
        check("pop3 Q",     Q,          32'h0);
        check("pop3 Empty", 32'(Empty), 32'd1);

        // Overflow drops the oldest entry
        step(1, 0, 0, 32'h10, 0, 0);
        step(1, 0, 0, 32'h20, 0, 0);
        step(1, 0, 0, 32'h30, 0, 0);
        step(1, 0, 0, 32'h40, 0, 0);
        step(1, 0, 0, 32'h50, 0, 0);
        check("ovf Full",     32'(Full),     32'd1);
        check("ovf Count",    32'(Count),    32'd4);
        check("ovf Overflow", 32'(Overflow), 32'd1);
        check("ovf Q",        Q,             32'h50);
        step(0, 1, 0, 0, 0, 0);
        check("ovf pop1 Q", Q, 32'h40);
        step(0, 1, 0, 0, 0, 0);
        check("ovf pop2 Q", Q, 32'h30);
        step(0, 1, 0, 0, 0, 0);
        check("ovf pop3 Q", Q, 32'h20);
        step(0, 1, 0, 0, 0, 0);
        check("ovf pop4 Q",     Q,          32'h0);
        check("ovf pop4 Empty", 32'(Empty), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        check("clr Overflow", 32'(Overflow), 32'd0);

        // Underflow, set beats clear, then clear alone
        step(0, 1, 0, 0, 0, 0);
        check("unf Underflow", 32'(Underflow), 32'd1);
        check("unf Count",     32'(Count),     32'd0);
        step(0, 1, 0, 0, 0, 1);
        check("unf set-wins", 32'(Underflow), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        check("unf clr", 32'(Underflow), 32'd0);

        // ClearFlags acts while disabled; the disabled Pop does not set Underflow
        step(0, 1, 0, 0, 0, 0);
        ClockEnable = 1'b0;
        step(0, 1, 0, 0, 0, 1);
        check("en0 clr Underflow", 32'(Underflow), 32'd0);
        ClockEnable = 1'b1;

        // Replace and Write-with-Pop
        step(1, 0, 0, 32'h100, 0, 0);
        step(1, 0, 0, 32'h200, 0, 0);
        step(1, 1, 0, 32'h999, 0, 0);
        check("repl Q",     Q,          32'h999);
        check("repl Count", 32'(Count), 32'd2);
        step(0, 1, 1, 0, 32'hABC, 0);
        check("wrpop Count", 32'(Count), 32'd1);
        check("wrpop Q",     Q,          32'h100);
        step(0, 1, 0, 0, 0, 0);

        // Replace on empty creates one entry
        step(1, 1, 0, 32'h77, 0, 0);
        check("repl0 Q",     Q,          32'h77);
        check("repl0 Count", 32'(Count), 32'd1);
        step(0, 1, 0, 0, 0, 0);

        // Overflow set beats a same-edge ClearFlags
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 0, 32'(i), 0, 0);
        step(1, 0, 0, 32'hA5, 0, 1);
        check("ovf set-wins", 32'(Overflow), 32'd1);
        step(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, 0, 0);

        // Write on empty, cs gating, write on non-empty
        step(0, 0, 1, 0, 32'h1234, 0);
        check("wr Q",     Q,          32'h1234);
        check("wr Count", 32'(Count), 32'd1);
        cs = 1'b1;
        @(negedge Clock);
        check("cs Q",     Q,          32'h0);
        check("cs Count", 32'(Count), 32'd1);
        cs = 1'b0;
        step(0, 0, 1, 0, 32'h4321, 0);
        check("wr2 Q",     Q,          32'h4321);
        check("wr2 Count", 32'(Count), 32'd1);

        // Reset mid-sequence at Count=3, alongside a Push
        step(1, 0, 0, 32'hB1, 0, 0);
        step(1, 0, 0, 32'hB2, 0, 0);
        check("pre-rst Count", 32'(Count), 32'd3);
        Reset = 1'b1;
        step(1, 0, 0, 32'hB3, 0, 0);
        Reset = 1'b0;
        check("rst Q",     Q,          32'h0);
        check("rst Count", 32'(Count), 32'd0);
        check("rst Empty", 32'(Empty), 32'd1);

        repeat (2) @(posedge Clock);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
